// File: rtl/cnn_bus_master.sv
// Bus initiator for the CNN 16x16 accelerator slave port: streams the operand words, starts the job, polls and fetches the result.
// Optional poll timeout is enabled by defining CNN_BUS_MASTER_TIMEOUT_EN.
module cnn_bus_master #(
    parameter int N_WORDS    = 16,
    parameter int START_BIT  = 29,
    parameter int POLL_GAP   = 4,
    parameter int POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [31:0] op_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        busy,
    output logic [6:0]  bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_wr_en,
    output logic        bus_rd_en,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        timeout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_POLL  = 3'd5;
    localparam logic [2:0] S_FETCH = 3'd6;
    localparam logic [2:0] S_OUT   = 3'd7;

    localparam int IDX_W = $clog2(2 * N_WORDS);
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(2 * N_WORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST    = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;
    localparam logic [6:0]       ADDR_START  = 7'(2 * N_WORDS);
    localparam logic [6:0]       ADDR_RESULT = 7'(2 * N_WORDS + 1);
    localparam logic [6:0]       ADDR_VALID  = 7'(2 * N_WORDS + 2);
    localparam logic [31:0]      START_WORD  = 32'd1 << START_BIT;

    if (POLL_LIMIT < 1 || POLL_GAP < 0) begin : g_bad_params
        $error("cnn_bus_master: POLL_LIMIT must be >= 1 and POLL_GAP >= 0");
    end

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             op_ready_q, op_ready_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [6:0]       bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic             bus_wr_en_q, bus_wr_en_d;
    logic             bus_rd_en_q, bus_rd_en_d;
    logic             enter_poll;

`ifdef CNN_BUS_MASTER_TIMEOUT_EN
    localparam int                PCNT_W     = $clog2(POLL_LIMIT + 1);
    localparam logic [PCNT_W-1:0] LIMIT_LAST = PCNT_W'(POLL_LIMIT - 1);

    logic [PCNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through the case can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        op_ready_d  = op_ready_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wr_en_d = bus_wr_en_q;
        bus_rd_en_d = bus_rd_en_q;
        enter_poll  = 1'b0;
`ifdef CNN_BUS_MASTER_TIMEOUT_EN
        poll_cnt_d  = poll_cnt_q;
        timeout_d   = 1'b0;
`endif

        case (state_q)
            S_IDLE, S_LOAD: begin
                op_ready_d = 1'b1;
                if (op_valid && op_ready_q) begin
                    state_d     = S_WR;
                    op_ready_d  = 1'b0;
                    bus_wr_en_d = 1'b1;
                    bus_addr_d  = 7'(idx_q);
                    bus_wdata_d = op_data;
                end
            end
            S_WR: begin
                if (bus_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        // Start beat follows the last operand write back-to-back.
                        state_d     = S_START;
                        bus_addr_d  = ADDR_START;
                        bus_wdata_d = START_WORD;
                    end else begin
                        state_d     = S_LOAD;
                        bus_wr_en_d = 1'b0;
                        op_ready_d  = 1'b1;
                    end
                end
            end
            S_START: begin
                if (bus_ready) begin
                    idx_d       = '0;
                    bus_wr_en_d = 1'b0;
                    enter_poll  = 1'b1;
`ifdef CNN_BUS_MASTER_TIMEOUT_EN
                    poll_cnt_d  = '0;
`endif
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d     = S_POLL;
                    bus_rd_en_d = 1'b1;
                    bus_addr_d  = ADDR_VALID;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_POLL: begin
                if (bus_ready) begin
                    if (bus_rdata[0]) begin
                        state_d    = S_FETCH;
                        bus_addr_d = ADDR_RESULT;
                    end else begin
                        bus_rd_en_d = 1'b0;
`ifdef CNN_BUS_MASTER_TIMEOUT_EN
                        if (poll_cnt_q == LIMIT_LAST) begin
                            timeout_d   = 1'b1;
                            res_data_d  = 32'hFFFF_FFFF;
                            res_valid_d = 1'b1;
                            state_d     = S_OUT;
                        end else begin
                            poll_cnt_d = poll_cnt_q + 1'b1;
                            enter_poll = 1'b1;
                        end
`else
                        enter_poll = 1'b1;
`endif
                    end
                end
            end
            S_FETCH: begin
                if (bus_ready) begin
                    res_data_d  = bus_rdata;
                    res_valid_d = 1'b1;
                    bus_rd_en_d = 1'b0;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A zero gap issues the next poll immediately, keeping the read strobe high.
        if (enter_poll) begin
            gap_d = '0;
            if (POLL_GAP == 0) begin
                state_d     = S_POLL;
                bus_rd_en_d = 1'b1;
                bus_addr_d  = ADDR_VALID;
            end else begin
                state_d = S_GAP;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            gap_q       <= '0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wr_en_q <= 1'b0;
            bus_rd_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wr_en_q <= bus_wr_en_d;
            bus_rd_en_q <= bus_rd_en_d;
        end
    end

`ifdef CNN_BUS_MASTER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign op_ready  = op_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != S_IDLE);
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wr_en = bus_wr_en_q;
    assign bus_rd_en = bus_rd_en_q;

endmodule

// File: tb/tb_cnn_bus_master.sv
// Scoreboard bench for cnn_bus_master: a slave responder with wait states, an expected-beat queue and a result queue.
`timescale 1ns/1ps
module tb_cnn_bus_master;

    localparam int          POLL_GAP   = 4;
    localparam int          POLL_LIMIT = 8;
    localparam logic [31:0] START_WORD = 32'h2000_0000;
    localparam logic [31:0] RESULT     = 32'h0000_0110;

    typedef struct packed {
        logic        is_rd;
        logic [6:0]  addr;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;
    logic [6:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_wr_en;
    logic        bus_rd_en;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        timeout;

    beat_t       bus_q[$];
    logic [31:0] res_q[$];

    int errors = 0;
    int checks = 0;

    // Responder configuration and per-job statistics.
    int wait_cycles;
    int valid_delay;
    int min_polls;
    bit never_valid;
    int polls_done;
    int reads_33;
    int timeout_pulses;
    int last_poll_cyc;
    int cyc;
    bit started;
    int since_start;

    always #5 clk = ~clk;

    cnn_bus_master #(.POLL_GAP(POLL_GAP), .POLL_LIMIT(POLL_LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_data   (op_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wr_en (bus_wr_en),
        .bus_rd_en (bus_rd_en),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .timeout   (timeout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input int i);
        return (i < 16) ? 32'(i + 1) : 32'd2;
    endfunction

    task automatic clear_stats();
        polls_done     = 0;
        reads_33       = 0;
        timeout_pulses = 0;
        last_poll_cyc  = -1;
        started        = 1'b0;
        since_start    = 0;
    endtask

    // Slave responder and bus checker; bus_ready/bus_rdata change only on the falling edge.
    task automatic monitor();
        int    cnt = 0;
        bit    stalled = 1'b0;
        logic  [40:0] snap = '0;
        beat_t obs;
        beat_t exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                cnt       = 0;
                stalled   = 1'b0;
                bus_ready = 1'b0;
            end else begin
                if (started) since_start++;
                if (timeout) timeout_pulses++;
                if (stalled)
                    check("bus_hold", 64'({bus_wr_en, bus_rd_en, bus_addr, bus_wdata}), 64'(snap));
                obs = '{is_rd: bus_rd_en, addr: bus_addr, data: bus_rd_en ? 32'd0 : bus_wdata};
                if ((bus_wr_en || bus_rd_en) && cnt == wait_cycles) begin
                    bus_ready = 1'b1;
                    bus_rdata = '0;
                    cnt       = 0;
                    stalled   = 1'b0;
                    check("one_strobe", 64'(bus_wr_en & bus_rd_en), 64'd0);
                    if (bus_rd_en && bus_addr == 7'd34) begin
                        bus_rdata = {31'd0, !never_valid && since_start >= valid_delay && polls_done >= min_polls};
                        if (last_poll_cyc >= 0)
                            check("poll_gap", 64'(cyc - last_poll_cyc), 64'(POLL_GAP + 1 + wait_cycles));
                        last_poll_cyc = cyc;
                        polls_done++;
                    end else begin
                        if (bus_rd_en && bus_addr == 7'd33) begin
                            bus_rdata = RESULT;
                            reads_33++;
                        end
                        if (bus_wr_en && bus_addr == 7'd32) begin
                            started     = 1'b1;
                            since_start = 0;
                        end
                        if (bus_q.size() == 0) begin
                            check("bus_unexpected", 64'(bus_q.size()), 64'd1);
                        end else begin
                            exp = bus_q.pop_front();
                            check("bus_beat", 64'(obs), 64'(exp));
                        end
                    end
                end else if (bus_wr_en || bus_rd_en) begin
                    bus_ready = 1'b0;
                    cnt++;
                    stalled   = 1'b1;
                    snap      = {bus_wr_en, bus_rd_en, bus_addr, bus_wdata};
                end else begin
                    bus_ready = 1'b0;
                    cnt       = 0;
                    stalled   = 1'b0;
                end
            end
        end
    endtask

    task automatic push_job(input bit is_timeout);
        for (int i = 0; i < 32; i++)
            bus_q.push_back('{is_rd: 1'b0, addr: 7'(i), data: word_of(i)});
        bus_q.push_back('{is_rd: 1'b0, addr: 7'd32, data: START_WORD});
        if (!is_timeout)
            bus_q.push_back('{is_rd: 1'b1, addr: 7'd33, data: 32'd0});
    endtask

    task automatic feed_words(input int n, input bit throttle);
        int i = 0;
        int budget = 0;
        bit phase = 1'b0;
        while (i < n && budget < 2000) begin
            @(negedge clk);
            budget++;
            phase    = !phase;
            op_valid = !throttle || phase;
            op_data  = word_of(i);
            if (op_valid && op_ready) i++;
        end
        check("feed_count", 64'(i), 64'(n));
    endtask

    task automatic run_job(input int wst, input bit throttle, input int hold, input bit is_timeout);
        logic [31:0] held;
        int n = 0;
        wait_cycles = wst;
        clear_stats();
        push_job(is_timeout);
        res_q.push_back(is_timeout ? 32'hFFFF_FFFF : RESULT);
        feed_words(32, throttle);
        @(negedge clk);
        op_valid = 1'b0;
        while (!res_valid && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("res_valid_seen", 64'(res_valid), 64'd1);
        held = res_data;
        for (int k = 0; k < hold; k++) begin
            op_valid = 1'b1;
            op_data  = 32'hDEAD_BEEF;
            @(negedge clk);
            check("res_stall", 64'({op_ready, res_valid, res_data}), 64'({1'b0, 1'b1, held}));
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        check("res_data", 64'(res_data), 64'(res_q.pop_front()));
        @(negedge clk);
        res_ready = 1'b0;
        check("idle_after", 64'({busy, res_valid, op_ready}), 64'(3'b001));
        check("bus_q_drained", 64'(bus_q.size()), 64'd0);
        check("result_reads", 64'(reads_33), is_timeout ? 64'd0 : 64'd1);
        check("timeout_pulses", 64'(timeout_pulses), is_timeout ? 64'd1 : 64'd0);
    endtask

    initial begin
        rst         = 1'b1;
        op_valid    = 1'b0;
        op_data     = '0;
        res_ready   = 1'b0;
        bus_ready   = 1'b0;
        bus_rdata   = '0;
        wait_cycles = 0;
        valid_delay = 10;
        min_polls   = 0;
        never_valid = 1'b0;
        cyc         = 0;
        clear_stats();
        fork
            monitor();
        join_none

        #2;
        check("rst_ctrl", 64'({op_ready, res_valid, busy, bus_wr_en, bus_rd_en, timeout, bus_addr}), 64'd0);
        check("rst_data", 64'({res_data, bus_wdata}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'({busy, op_ready}), 64'(2'b01));

        // Basic job, zero-wait bus, valid 10 cycles after start.
        run_job(0, 1'b0, 0, 1'b0);
        check("basic_polled", 64'(polls_done >= 1), 64'd1);

        // Three wait states on every beat.
        run_job(3, 1'b0, 0, 1'b0);

        // Producer toggling, consumer stalled 20 cycles.
        run_job(0, 1'b1, 20, 1'b0);

        // Valid only on the third poll.
        valid_delay = 0;
        min_polls   = 2;
        run_job(0, 1'b0, 0, 1'b0);
        check("poll_count", 64'(polls_done), 64'd3);

        // Reset after 10 operand words, then a fresh job must restart at address 0.
        valid_delay = 10;
        min_polls   = 0;
        wait_cycles = 0;
        clear_stats();
        push_job(1'b0);
        feed_words(10, 1'b0);
        @(negedge clk);
        op_valid = 1'b0;
        check("busy_mid_load", 64'({busy, bus_wr_en}), 64'(2'b11));
        #2 rst = 1'b1;
        #1;
        check("rst_mid_ctrl", 64'({op_ready, res_valid, busy, bus_wr_en, bus_rd_en, timeout, bus_addr}), 64'd0);
        check("rst_mid_data", 64'({res_data, bus_wdata}), 64'd0);
        bus_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_job(0, 1'b0, 0, 1'b0);

`ifdef CNN_BUS_MASTER_TIMEOUT_EN
        // Responder never signals valid: polling must be abandoned after POLL_LIMIT polls.
        never_valid = 1'b1;
        run_job(0, 1'b0, 0, 1'b1);
        check("timeout_polls", 64'(polls_done), 64'(POLL_LIMIT));
        never_valid = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
